// File: rtl/uart_rx.sv
// UART receiver: start/data/stop deframing with a single mid-bit sample per bit.
// Reports each completed frame with a one-cycle done tick and a framing-error flag.
module uart_rx #(
    parameter int p_clkfreq  = 100_000_000,
    parameter int p_baudrate = 10_000_000,
    parameter int p_stopbit  = 2,
    parameter int p_databits = 10
) (
    input  logic                  clk,
    input  logic                  rst_n_i,
    input  logic                  rx_i,
    output logic [p_databits-1:0] dout_o,
    output logic                  rx_done_tick_o,
    output logic                  frame_err_o,
    output logic                  rx_busy_o
);

    localparam int C_BT   = p_clkfreq / p_baudrate;
    localparam int CW     = $clog2(C_BT + 1);
    localparam int IMAX   = (p_databits > p_stopbit) ? p_databits : p_stopbit;
    localparam int IW     = $clog2(IMAX + 1);

    localparam logic [CW-1:0] CNT_FULL   = CW'(C_BT - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(C_BT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST_D = IW'(p_databits - 1);
    localparam logic [IW-1:0] IDX_LAST_S = IW'(p_stopbit - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                  state;
    logic                    rx_meta;
    logic                    rx_s;
    logic                    rx_s_d;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [p_databits-1:0]   shreg;
    logic                    err;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    // All three reset to the idle (high) line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            err            <= 1'b0;
            dout_o         <= '0;
            rx_done_tick_o <= 1'b0;
            frame_err_o    <= 1'b0;
            rx_busy_o      <= 1'b0;
        end else begin
            rx_done_tick_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Edge-triggered so a held-low (break) line cannot restart a frame.
                    if (!rx_s && rx_s_d) begin
                        state     <= S_START;
                        cnt       <= '0;
                        rx_busy_o <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == CNT_HALF) begin
                        if (!rx_s) begin
                            state <= S_DATA;
                            cnt   <= '0;
                            idx   <= '0;
                        end else begin
                            state     <= S_IDLE;
                            rx_busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[p_databits-1:1]};
                        if (idx == IDX_LAST_D) begin
                            state <= S_STOP;
                            idx   <= '0;
                            err   <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        // Accept mid last stop bit so an immediately following start edge is seen.
                        if (idx == IDX_LAST_S) begin
                            dout_o         <= shreg;
                            frame_err_o    <= err | ~rx_s;
                            rx_done_tick_o <= 1'b1;
                            rx_busy_o      <= 1'b0;
                            idx            <= '0;
                            state          <= S_IDLE;
                        end else begin
                            err <= err | ~rx_s;
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    rx_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a model transmitter queues expected words,
// a monitor pops and checks them on every done tick.
module tb_uart_rx;

    localparam int BT = 10;

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       rx_i = 1'b1;
    logic [9:0] dout_o;
    logic       rx_done_tick_o;
    logic       frame_err_o;
    logic       rx_busy_o;

    typedef struct packed {
        logic [9:0] data;
        logic       err;
    } exp_t;

    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;
    longint     start_t = 0;
    logic [9:0] last_dout = '0;
    bit         done = 1'b0;

    uart_rx #(
        .p_clkfreq (100_000_000),
        .p_baudrate(10_000_000),
        .p_stopbit (2),
        .p_databits(10)
    ) dut (
        .clk           (clk),
        .rst_n_i       (rst_n_i),
        .rx_i          (rx_i),
        .dout_o        (dout_o),
        .rx_done_tick_o(rx_done_tick_o),
        .frame_err_o   (frame_err_o),
        .rx_busy_o     (rx_busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        rx_i = b;
        wait_clks(BT);
    endtask

    task automatic send_frame(input logic [9:0] data, input logic stop2, input logic push);
        exp_t e;
        if (push) begin
            e.data = data;
            e.err  = ~stop2;
            q.push_back(e);
        end
        start_t = longint'($time);
        bit_out(1'b0);
        for (int i = 0; i < 10; i++) bit_out(data[i]);
        bit_out(1'b1);
        bit_out(stop2);
    endtask

    // Monitor: compares every done tick against the head of the scoreboard.
    initial begin
        exp_t   e;
        longint lat;
        forever begin
            @(negedge clk);
            if (rx_done_tick_o === 1'b1) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tick: got dout %0h err %0b, expected no tick", dout_o, frame_err_o);
                end else begin
                    e = q.pop_front();
                    lat = (longint'($time) - start_t) / 10;
                    chk("dout", 32'(dout_o), 32'(e.data));
                    chk("frame_err", 32'(frame_err_o), 32'(e.err));
                    tests++;
                    if (lat < 126 || lat > 128) begin
                        fails++;
                        $display("FAIL latency: got %0d clocks, expected 126..128", lat);
                    end
                    last_dout = e.data;
                end
            end
        end
    end

    initial begin
        int  rise;
        int  fall;
        // Reset with idle line.
        rx_i    = 1'b1;
        rst_n_i = 1'b0;
        wait_clks(3);
        rst_n_i = 1'b1;
        wait_clks(20);
        chk("rst_dout", 32'(dout_o), 32'h0);
        chk("rst_tick", 32'(rx_done_tick_o), 32'h0);
        chk("rst_err", 32'(frame_err_o), 32'h0);
        chk("rst_busy", 32'(rx_busy_o), 32'h0);

        // Single frame, then idle.
        send_frame(10'b1100110011, 1'b1, 1'b1);
        wait_clks(20);

        // Back-to-back: second start edge right after the first frame's stop bits.
        send_frame(10'b1100110011, 1'b1, 1'b1);
        send_frame(10'b1110001110, 1'b1, 1'b1);
        wait_clks(20);

        // Glitch: 3 clocks low.
        rise = -1;
        fall = -1;
        rx_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rx_busy_o && rise < 0) rise = i;
        end
        rx_i = 1'b1;
        for (int i = 3; i < 20; i++) begin
            @(negedge clk);
            if (rx_busy_o && rise < 0) rise = i;
            if (!rx_busy_o && rise >= 0 && fall < 0) fall = i;
        end
        chk("glitch_busy_rose", 32'(rise >= 0), 32'h1);
        tests++;
        if (fall < 0 || (fall - rise) > 8) begin
            fails++;
            $display("FAIL glitch_busy_fall: rise %0d fall %0d, expected fall within 8 clocks", rise, fall);
        end
        chk("glitch_dout", 32'(dout_o), 32'(10'b1110001110));
        @(posedge clk);
        #1;
        wait_clks(10);

        // Framing error on 2nd stop bit, line then held low as a break.
        send_frame(10'b1010101010, 1'b0, 1'b1);
        rx_i = 1'b0;
        wait_clks(500);
        rx_i = 1'b1;
        wait_clks(30);
        chk("break_dout_held", 32'(dout_o), 32'(10'b1010101010));
        chk("break_err_held", 32'(frame_err_o), 32'h1);
        send_frame(10'b0000011111, 1'b1, 1'b1);
        wait_clks(20);

        // Reset in the middle of the data bits.
        rx_i = 1'b0;
        wait_clks(BT);
        bit_out(1'b1);
        bit_out(1'b0);
        rx_i = 1'b1;
        wait_clks(5);
        rst_n_i = 1'b0;
        wait_clks(2);
        chk("midrst_dout", 32'(dout_o), 32'h0);
        chk("midrst_err", 32'(frame_err_o), 32'h0);
        chk("midrst_busy", 32'(rx_busy_o), 32'h0);
        chk("midrst_tick", 32'(rx_done_tick_o), 32'h0);
        rst_n_i = 1'b1;
        wait_clks(150);
        chk("post_rst_idle_dout", 32'(dout_o), 32'h0);
        send_frame(10'b1110001110, 1'b1, 1'b1);
        wait_clks(30);

        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: simulation did not complete");
            $fatal(1);
        end
    end

endmodule
